// File: rtl/mem_core_port_arbiter.sv
// Round-robin arbiter that shares one memory_core access port among NREQ requesters.
// It also tracks outstanding reads in a tag pipeline and routes each response back to its requester.
module mem_core_port_arbiter #(
  parameter int NREQ     = 2,
  parameter int DW       = 16,
  parameter int AW       = 16,
  parameter int READ_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic               flush,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_wen,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [AW-1:0]      mem_addr_in,
  output logic [DW-1:0]      mem_data_in,
  output logic               mem_wen_in,
  output logic               mem_ren_in,
  input  logic [DW-1:0]      mem_data_out,
  input  logic               mem_valid_out,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_data,
  output logic               rsp_err
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int LAST = READ_LAT - 1;

  typedef struct packed {
    logic          vld;
    logic [PW-1:0] id;
  } tag_t;

  logic [PW-1:0]         ptr_q, ptr_d;
  tag_t [READ_LAT-1:0]   tag_q, tag_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  gnt_vld;
  logic [PW-1:0]         gnt_idx;

  // Scan offsets from the far end down so the requester closest to ptr wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (reset && clk_en && !flush) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        for (int i = 0; i < NREQ; i++) begin
          if (req_valid[i] && ((int'(ptr_q) + k) % NREQ) == i) begin
            gnt_vld = 1'b1;
            gnt_idx = PW'(i);
          end
        end
      end
    end
  end

  always_comb begin
    req_ready   = '0;
    mem_wen_in  = 1'b0;
    mem_ren_in  = 1'b0;
    mem_addr_in = '0;
    mem_data_in = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_vld && gnt_idx == PW'(i)) begin
        req_ready[i] = 1'b1;
        mem_addr_in  = req_addr[i*AW +: AW];
        if (req_wen[i]) begin
          mem_wen_in  = 1'b1;
          mem_data_in = req_data[i*DW +: DW];
        end else begin
          mem_ren_in = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_d     = ptr_q;
    tag_d     = tag_q;
    rsp_err_d = rsp_err_q;
    if (clk_en) begin
      if (flush) begin
        ptr_d = '0;
        tag_d = '0;
      end else begin
        if (gnt_vld) ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        tag_d[0].vld = mem_ren_in;
        tag_d[0].id  = gnt_idx;
        for (int s = 1; s < READ_LAT; s++) tag_d[s] = tag_q[s-1];
        // The core must answer exactly when the tag pipeline expects it.
        if (tag_q[LAST].vld != mem_valid_out) rsp_err_d = 1'b1;
      end
    end
  end

  // NOTE: reset is sampled on the clock edge only; it is not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q     <= '0;
      tag_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update together.
      ptr_q     <= ptr_d;
      tag_q     <= tag_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (reset && tag_q[LAST].vld) begin
      rsp_data = mem_data_out;
      for (int i = 0; i < NREQ; i++) begin
        if (tag_q[LAST].id == PW'(i)) rsp_valid[i] = 1'b1;
      end
    end
  end

  assign rsp_err = rsp_err_q;

endmodule

// File: tb/tb_mem_core_port_arbiter.sv
// Directed bench for mem_core_port_arbiter with a behavioural memory_core (READ_LAT=2).
// Each accepted read queues its expected response; a monitor checks every response strobe against that queue.
module tb_mem_core_port_arbiter;

  localparam int NREQ     = 2;
  localparam int DW       = 16;
  localparam int AW       = 16;
  localparam int READ_LAT = 2;

  logic               clk = 1'b0;
  logic               reset, clk_en, flush, force_v;
  logic [NREQ-1:0]    req_valid, req_wen, req_ready, rsp_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [AW-1:0]      mem_addr_in;
  logic [DW-1:0]      mem_data_in, mem_data_out, rsp_data;
  logic               mem_wen_in, mem_ren_in, mem_valid_out, rsp_err;

  typedef struct {
    int          id;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   en_cyc = 0;

  always #5 clk = ~clk;

  mem_core_port_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush),
    .req_valid(req_valid), .req_wen(req_wen), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .mem_addr_in(mem_addr_in), .mem_data_in(mem_data_in),
    .mem_wen_in(mem_wen_in), .mem_ren_in(mem_ren_in), .mem_data_out(mem_data_out),
    .mem_valid_out(mem_valid_out), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  // Behavioural memory_core: frozen by clk_en, pipeline cleared by flush and reset.
  logic [DW-1:0]       core_mem [0:255];
  logic [READ_LAT-1:0] cv;
  logic [DW-1:0]       cd [READ_LAT];

  initial for (int i = 0; i < 256; i++) core_mem[i] = '0;

  always @(posedge clk) begin
    if (!reset) begin
      cv <= '0;
    end else if (clk_en) begin
      if (flush) begin
        cv <= '0;
      end else begin
        if (mem_wen_in) core_mem[mem_addr_in[7:0]] <= mem_data_in;
        for (int s = READ_LAT - 1; s > 0; s--) begin
          cv[s] <= cv[s-1];
          cd[s] <= cd[s-1];
        end
        cv[0] <= mem_ren_in;
        cd[0] <= core_mem[mem_addr_in[7:0]];
      end
    end
  end

  assign mem_valid_out = cv[READ_LAT-1] | force_v;
  assign mem_data_out  = cd[READ_LAT-1];

  always @(posedge clk) if (reset && clk_en) en_cyc <= en_cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes a response on every enabled cycle that presents one.
  always @(negedge clk) begin
    if (reset && clk_en && (|rsp_valid)) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp_unexpected: got rsp_valid=%b expected none (t=%0t)", rsp_valid, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_valid", 32'(rsp_valid), (e.id == 1) ? 32'h2 : 32'h1);
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        check("rsp_latency", 32'(en_cyc), 32'(e.due));
      end
    end
  end

  // One cycle of stimulus; exp_rdy and exp_rd are the hand-computed grant and read data.
  task automatic step(input logic [1:0] v, input logic [1:0] w,
                      input logic [15:0] a0, input logic [15:0] d0,
                      input logic [15:0] a1, input logic [15:0] d1,
                      input logic [1:0] exp_rdy, input logic push, input logic [15:0] exp_rd);
    int          gid;
    logic        exp_w, exp_r;
    logic [15:0] exp_a, exp_d;
    req_valid = v;
    req_wen   = w;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
    gid   = exp_rdy[1] ? 1 : 0;
    exp_w = |(exp_rdy & w);
    exp_r = (exp_rdy != 2'b00) && !exp_w;
    exp_a = (exp_rdy == 2'b00) ? 16'h0 : (gid == 1 ? a1 : a0);
    exp_d = exp_w ? (gid == 1 ? d1 : d0) : 16'h0;
    @(negedge clk);
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("mem_wen_in", 32'(mem_wen_in), 32'(exp_w));
    check("mem_ren_in", 32'(mem_ren_in), 32'(exp_r));
    check("mem_addr_in", 32'(mem_addr_in), 32'(exp_a));
    check("mem_data_in", 32'(mem_data_in), 32'(exp_d));
    if (push && exp_r) sb.push_back('{id: gid, data: exp_rd, due: en_cyc + READ_LAT});
    @(posedge clk);
    #1;
    req_valid = 2'b00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00, 1'b0, 16'h0);
  endtask

  task automatic reset_cycle();
    req_valid = 2'b11;
    req_wen   = 2'b00;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_mem_wen", 32'(mem_wen_in), 32'h0);
    check("rst_mem_ren", 32'(mem_ren_in), 32'h0);
    check("rst_mem_addr", 32'(mem_addr_in), 32'h0);
    check("rst_mem_data", 32'(mem_data_in), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data", 32'(rsp_data), 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; clk_en = 1'b1; flush = 1'b0; force_v = 1'b0;
    req_valid = 2'b11; req_wen = 2'b00; req_addr = '0; req_data = '0;

    // Reset held with every requester valid.
    repeat (4) reset_cycle();
    reset = 1'b1;

    // First cycle after release: requester 0, then requester 1.
    step(2'b11, 2'b00, 16'h0010, 16'h0, 16'h0011, 16'h0, 2'b01, 1'b1, 16'h0000);
    step(2'b10, 2'b00, 16'h0010, 16'h0, 16'h0011, 16'h0, 2'b10, 1'b1, 16'h0000);

    // Single write then read-back.
    step(2'b01, 2'b01, 16'h0005, 16'hBEEF, 16'h0, 16'h0, 2'b01, 1'b1, 16'h0);
    step(2'b01, 2'b00, 16'h0005, 16'h0, 16'h0, 16'h0, 2'b01, 1'b1, 16'hBEEF);
    step(2'b10, 2'b10, 16'h0, 16'h0, 16'h0006, 16'h1234, 2'b10, 1'b1, 16'h0);

    // Both requesters reading continuously: grants alternate.
    step(2'b11, 2'b00, 16'h0005, 16'h0, 16'h0006, 16'h0, 2'b01, 1'b1, 16'hBEEF);
    step(2'b11, 2'b00, 16'h0005, 16'h0, 16'h0006, 16'h0, 2'b10, 1'b1, 16'h1234);
    step(2'b11, 2'b00, 16'h0005, 16'h0, 16'h0006, 16'h0, 2'b01, 1'b1, 16'hBEEF);
    step(2'b11, 2'b00, 16'h0005, 16'h0, 16'h0006, 16'h0, 2'b10, 1'b1, 16'h1234);

    // Interleaved write and read from different requesters.
    step(2'b11, 2'b01, 16'h0007, 16'hCAFE, 16'h0006, 16'h0, 2'b01, 1'b1, 16'h0);
    step(2'b11, 2'b01, 16'h0007, 16'hCAFE, 16'h0006, 16'h0, 2'b10, 1'b1, 16'h1234);
    step(2'b10, 2'b00, 16'h0, 16'h0, 16'h0007, 16'h0, 2'b10, 1'b1, 16'hCAFE);
    idle(2);

    // Clock enable dropped for 3 cycles with a read in flight.
    step(2'b01, 2'b00, 16'h0007, 16'h0, 16'h0, 16'h0, 2'b01, 1'b1, 16'hCAFE);
    clk_en = 1'b0;
    repeat (3) step(2'b11, 2'b00, 16'h0005, 16'h0, 16'h0006, 16'h0, 2'b00, 1'b0, 16'h0);
    clk_en = 1'b1;
    idle(3);

    // Flush the cycle after a read from requester 1: read dropped.
    step(2'b10, 2'b00, 16'h0, 16'h0, 16'h0006, 16'h0, 2'b10, 1'b0, 16'h0);
    flush = 1'b1;
    step(2'b11, 2'b00, 16'h0005, 16'h0, 16'h0006, 16'h0, 2'b00, 1'b0, 16'h0);
    flush = 1'b0;
    // Grant requester 0 (ptr -> 1), flush, then both valid must pick requester 0 again.
    step(2'b01, 2'b00, 16'h0005, 16'h0, 16'h0, 16'h0, 2'b01, 1'b0, 16'h0);
    flush = 1'b1;
    step(2'b11, 2'b00, 16'h0005, 16'h0, 16'h0006, 16'h0, 2'b00, 1'b0, 16'h0);
    flush = 1'b0;
    step(2'b11, 2'b00, 16'h0005, 16'h0, 16'h0006, 16'h0, 2'b01, 1'b1, 16'hBEEF);
    idle(3);
    check("rsp_err_after_flush", 32'(rsp_err), 32'h0);

    // Core valid with nothing outstanding: sticky error.
    force_v = 1'b1;
    idle(1);
    force_v = 1'b0;
    check("rsp_err_set", 32'(rsp_err), 32'h1);
    idle(2);
    check("rsp_err_sticky", 32'(rsp_err), 32'h1);

    // Reset with a read in flight: read dropped, error cleared.
    step(2'b01, 2'b00, 16'h0005, 16'h0, 16'h0, 16'h0, 2'b01, 1'b0, 16'h0);
    reset = 1'b0;
    repeat (2) reset_cycle();
    reset = 1'b1;
    check("rsp_err_cleared", 32'(rsp_err), 32'h0);
    idle(4);
    check("rsp_err_after_reset", 32'(rsp_err), 32'h0);
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
